// File: rtl/cmp_pkg.sv
// Shared definitions for the two-requester compare arbiter: FSM states,
// flag bit positions and the round-robin winner selection.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CMP,
        ST_DONE
    } state_e;

    localparam int FLAGS_W = 6;

    localparam int FLG_GT = 0;
    localparam int FLG_LT = 1;
    localparam int FLG_GE = 2;
    localparam int FLG_LE = 3;
    localparam int FLG_EQ = 4;
    localparam int FLG_NE = 5;

    // With both requesting, the one not served last wins; a lone requester always wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/cmp_flags.sv
// Combinational magnitude comparator producing the six relation flags.
// Defining CMP_SIGNED_EN switches the operands to two's-complement interpretation.
module cmp_flags
    import cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic [FLAGS_W-1:0] flags
);

    logic isGt;
    logic isEq;

    always_comb begin
`ifdef CMP_SIGNED_EN
        isGt = $signed(a) > $signed(b);
`else
        isGt = a > b;
`endif
        isEq = (a == b);
    end

    // Every other relation follows from greater-than and equality.
    always_comb begin
        flags         = '0;
        flags[FLG_GT] = isGt;
        flags[FLG_LT] = ~isGt & ~isEq;
        flags[FLG_GE] = isGt | isEq;
        flags[FLG_LE] = ~isGt;
        flags[FLG_EQ] = isEq;
        flags[FLG_NE] = ~isEq;
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter granting one of two requesters a shared comparator:
// IDLE -> LOAD -> CMP -> DONE, all outputs registered. See CMP_SIGNED_EN in cmp_flags.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [W-1:0]       a0,
    input  logic [W-1:0]       b0,
    input  logic [W-1:0]       a1,
    input  logic [W-1:0]       b1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [FLAGS_W-1:0] flags,
    output logic               cmp_en,
    output logic               busy
);

    state_e             state_q;
    logic [1:0]         gnt_q;
    logic [1:0]         done_q;
    logic [FLAGS_W-1:0] flags_q;
    logic               cmp_en_q;
    logic               busy_q;
    logic               last_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;

    logic               winner_d;
    logic [W-1:0]       a_d;
    logic [W-1:0]       b_d;
    logic [FLAGS_W-1:0] flags_d;

    always_comb begin
        winner_d = pick_winner(req, last_q);
        a_d      = winner_d ? a1 : a0;
        b_d      = winner_d ? b1 : b0;
    end

    cmp_flags #(.W(W)) u_flags (
        .a     (a_q),
        .b     (b_q),
        .flags (flags_d)
    );

    // Reset leaves the pointer on requester 1 so requester 0 is served first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            flags_q  <= '0;
            cmp_en_q <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        state_q <= ST_LOAD;
                        gnt_q   <= winner_d ? 2'b10 : 2'b01;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q  <= ST_CMP;
                    cmp_en_q <= 1'b1;
                end
                ST_CMP: begin
                    state_q <= ST_DONE;
                    flags_q <= flags_d;
                    done_q  <= gnt_q;
                    last_q  <= gnt_q[1];
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= '0;
                    done_q   <= '0;
                    flags_q  <= '0;
                    cmp_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign flags  = flags_q;
    assign cmp_en = cmp_en_q;
    assign busy   = busy_q;

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, meaning the operand width in bits.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  2  per-requester compare request, level, held until its done pulse.
REQ-005 SHALL have port a0, b0  input  W each  requester-0 operands.
REQ-006 SHALL have port a1, b1  input  W each  requester-1 operands.
REQ-007 SHALL have port gnt  output  2  one-hot grant, identifies the requester being served.
REQ-008 SHALL have port done  output  2  one-hot, one-cycle completion pulse to the served requester.
REQ-009 SHALL have port flags  output  6  comparison result, valid while done is nonzero.
REQ-010 SHALL have port cmp_en  output  1  enable for the shared tri-state comparison outputs.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, CMP and DONE.
REQ-013 IDLE SHALL move to LOAD when req is nonzero, otherwise stay in IDLE.
REQ-014 LOAD, CMP and DONE SHALL each last exactly one cycle, then the FSM returns to IDLE.
REQ-015 On the IDLE->LOAD edge, the FSM SHALL set gnt and latch the winner's a and b into internal registers.
REQ-016 gnt SHALL hold through LOAD, CMP and DONE, and SHALL be 0 in IDLE.
REQ-017 Arbitration SHALL be round-robin with a 1-bit last-served pointer.
- Single request: that requester wins.
- Both requesting: the requester not last served wins.
REQ-018 cmp_en SHALL be high only in CMP and DONE.
REQ-019 In CMP, flags SHALL be computed from the latched operands and registered at the end of CMP.
REQ-020 flags bit encoding SHALL be:
- [0] a>b, [1] a<b, [2] a>=b, [3] a<=b, [4] a==b, [5] a!=b.
REQ-021 In DONE, done SHALL equal gnt for one cycle; flags SHALL be 0 in every other state.
REQ-022 Latency: req first sampled high at edge N SHALL produce done at cycle N+3.
REQ-023 Back-to-back: req held after done SHALL re-arbitrate in the next IDLE cycle, giving a minimum 4-cycle period per grant.
REQ-024 Operand changes after LOAD SHALL NOT affect the result in progress.
REQ-025 A req deassertion mid-operation SHALL NOT abort the operation: done still pulses and the pointer still updates.
REQ-026 The last-served pointer SHALL update on entry to DONE.

Reset
REQ-027 rst_n low SHALL asynchronously force the following, regardless of the current state:
- FSM = IDLE
- gnt = 0, done = 0, flags = 0, cmp_en = 0, busy = 0
- operand registers = 0
- last-served pointer = 1, so requester 0 wins first
REQ-028 After rst_n rises, the first arbitration SHALL occur at the first rising clk edge with req nonzero.

Configuration
REQ-029 With macro CMP_SIGNED_EN defined, comparisons SHALL treat operands as two's-complement signed values.
REQ-030 Without CMP_SIGNED_EN, comparisons SHALL be unsigned.
REQ-031 The macro SHALL NOT change any port, state or timing; only the flag values differ.

Structure
REQ-032 Shared package cmp_pkg SHALL hold:
- the FSM state enumeration
- flag bit-index constants FLG_GT, FLG_LT, FLG_GE, FLG_LE, FLG_EQ, FLG_NE
- the flags width constant (6)
REQ-033 Combinational flag generation SHALL be a single sub-module, cmp_flags (inputs a, b; output 6-bit flags), instantiated once.

Verification
REQ-034 Reset, then req=01, a0=8'h05, b0=8'h03 -> gnt=01 at N+1, cmp_en high at N+2 and N+3, done=01 at N+3, flags=6'b100101, busy low at N+4.
REQ-035 req=11 held after reset, a0=b0=a1=b1=8'h7A -> grants alternate 01, 10, 01; each done carries flags=6'b011100; done pulses at a 4-cycle spacing.
REQ-036 Unsigned build, a1=8'h80, b1=8'h01 -> flags=6'b100101; CMP_SIGNED_EN build, same operands -> flags=6'b101010.
REQ-037 a0 changed from 8'h10 to 8'hFF during CMP with b0=8'h20 -> flags=6'b101010, reflecting the latched 8'h10.
REQ-038 rst_n pulsed low during CMP -> all outputs 0 immediately, no done pulse; a subsequent req=11 grants requester 0 first.
REQ-039 req=10 dropped during LOAD -> done=10 still pulses at N+3, and the next req=11 grants requester 0.
